// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-stage branch resolution for a MIPS-style pipeline.
// Decodes beq/bne/blez/bgtz/bltz/bgez. It resolves the branch as soon as the
// forwarded operands are final. While the operands are not final it stalls
// decode, and it raises a sticky error if the wait lasts MAX_WAIT cycles.
// A taken branch drives a one-cycle redirect with the registered target.
// A branch found in the delay slot of a redirect is flagged as an error.
// Ports:
//   clk, reset          clock, async active-low reset
//   instr_d, pc_d       decode-stage instruction and its PC
//   valid_d             instr_d is a real instruction
//   opnd_ready          rd1/rd2 hold final forwarded values
//   rd1, rd2            rs / rt operands
//   hold                pipeline freeze (no state advances)
//   stall_d             combinational: freeze fetch/decode
//   redirect_valid/pc   registered redirect request and target
//   br_cnt, tk_cnt      saturating resolved / taken branch counters
//   err                 sticky error (wait timeout or branch in delay slot)
module branch_ctrl #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    input  logic        valid_d,
    input  logic        opnd_ready,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic        hold,
    output logic        stall_d,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_cnt,
    output logic [15:0] tk_cnt,
    output logic        err
);

    localparam int unsigned CW  = $clog2(MAX_WAIT + 2);
    localparam int unsigned CW1 = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_BEQ  = 3'd0,
        K_BNE  = 3'd1,
        K_BLEZ = 3'd2,
        K_BGTZ = 3'd3,
        K_BLTZ = 3'd4,
        K_BGEZ = 3'd5
    } br_kind_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     wait_cnt, wait_nxt;
    logic [CW1-1:0]    wait_inc;
    logic              timeout;
    br_kind_t          pend_kind, pend_kind_nxt;
    logic [31:0]       pend_tgt, pend_tgt_nxt;

    logic [5:0]        op;
    logic [4:0]        rt;
    logic              dec_br;
    br_kind_t          dec_kind;
    logic [31:0]       imm_ext;
    logic [31:0]       dec_tgt;

    logic              resolve;
    logic              res_taken;
    br_kind_t          res_kind;
    logic [31:0]       res_tgt;
    logic              set_err;
    logic              stall_c;
    logic              unused_rs;

    // Taken condition for each branch kind; comparisons against zero are signed.
    function automatic logic br_taken(input br_kind_t k, input logic [31:0] a,
                                      input logic [31:0] b);
        logic t;
        t = 1'b0;
        case (k)
            K_BEQ:   t = (a == b);
            K_BNE:   t = (a != b);
            K_BLEZ:  t = ($signed(a) <= 32'sd0);
            K_BGTZ:  t = ($signed(a) > 32'sd0);
            K_BLTZ:  t = a[31];
            K_BGEZ:  t = ~a[31];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign op        = instr_d[31:26];
    assign rt        = instr_d[20:16];
    assign unused_rs = ^instr_d[25:21];
    assign imm_ext   = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign dec_tgt   = pc_d + 32'd4 + imm_ext;
    assign wait_inc  = CW1'(wait_cnt) + CW1'(1);
    assign timeout   = (wait_inc >= CW1'(MAX_WAIT));

    // Branch decode; REGIMM is a branch only for rt = bltz/bgez.
    always_comb begin
        dec_br   = 1'b0;
        dec_kind = K_BEQ;
        if (valid_d) begin
            case (op)
                6'b000100: begin dec_br = 1'b1; dec_kind = K_BEQ;  end
                6'b000101: begin dec_br = 1'b1; dec_kind = K_BNE;  end
                6'b000110: begin dec_br = 1'b1; dec_kind = K_BLEZ; end
                6'b000111: begin dec_br = 1'b1; dec_kind = K_BGTZ; end
                6'b000001: begin
                    if (rt == 5'b00000) begin
                        dec_br   = 1'b1;
                        dec_kind = K_BLTZ;
                    end else if (rt == 5'b00001) begin
                        dec_br   = 1'b1;
                        dec_kind = K_BGEZ;
                    end
                end
                default: dec_br = 1'b0;
            endcase
        end
    end

    // Next-state, resolution and stall logic.
    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        pend_kind_nxt = pend_kind;
        pend_tgt_nxt  = pend_tgt;
        resolve       = 1'b0;
        res_kind      = dec_kind;
        res_tgt       = dec_tgt;
        set_err       = 1'b0;
        stall_c       = 1'b0;

        case (state)
            S_IDLE: begin
                if (dec_br) begin
                    if (opnd_ready) begin
                        resolve = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        if (timeout) begin
                            set_err  = 1'b1;
                            wait_nxt = '0;
                        end else begin
                            state_nxt     = S_WAIT;
                            wait_nxt      = wait_inc[CW-1:0];
                            pend_kind_nxt = dec_kind;
                            pend_tgt_nxt  = dec_tgt;
                        end
                    end
                end
            end
            S_WAIT: begin
                // The decoded branch was captured on entry; only operands are live.
                res_kind = pend_kind;
                res_tgt  = pend_tgt;
                if (opnd_ready) begin
                    resolve   = 1'b1;
                    state_nxt = S_IDLE;
                    wait_nxt  = '0;
                end else begin
                    stall_c = 1'b1;
                    if (timeout) begin
                        set_err   = 1'b1;
                        state_nxt = S_IDLE;
                        wait_nxt  = '0;
                    end else begin
                        wait_nxt = wait_inc[CW-1:0];
                    end
                end
            end
            S_REDIR: begin
                state_nxt = S_IDLE;
                if (dec_br) begin
                    set_err = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        res_taken = br_taken(res_kind, rd1, rd2);
        if (resolve && res_taken) begin
            state_nxt = S_REDIR;
        end

        // Freeze everything except the combinational stall.
        if (hold) begin
            state_nxt     = state;
            wait_nxt      = wait_cnt;
            pend_kind_nxt = pend_kind;
            pend_tgt_nxt  = pend_tgt;
            resolve       = 1'b0;
            set_err       = 1'b0;
        end
    end

    assign stall_d = stall_c & reset;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            pend_kind      <= K_BEQ;
            pend_tgt       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            br_cnt         <= '0;
            tk_cnt         <= '0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_nxt;
            pend_kind      <= pend_kind_nxt;
            pend_tgt       <= pend_tgt_nxt;
            redirect_valid <= (state_nxt == S_REDIR);
            if (resolve && res_taken) begin
                redirect_pc <= res_tgt;
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (resolve) begin
                if (br_cnt != 16'hFFFF) begin
                    br_cnt <= br_cnt + 16'd1;
                end
                if (res_taken && (tk_cnt != 16'hFFFF)) begin
                    tk_cnt <= tk_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus a randomized
// run compared against a transaction-level model of branch resolution.
module tb_branch_ctrl;

    localparam int MW = 8;

    logic        clk;
    logic        reset;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        opnd_ready;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        hold;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt;
    logic [15:0] tk_cnt;
    logic        err;

    int n_vec;
    int n_err;

    branch_ctrl #(.MAX_WAIT(MW)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .valid_d        (valid_d),
        .opnd_ready     (opnd_ready),
        .rd1            (rd1),
        .rd2            (rd2),
        .hold           (hold),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .br_cnt         (br_cnt),
        .tk_cnt         (tk_cnt),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] o, input logic [4:0] r,
                                       input logic [15:0] imm);
        return {o, 5'd3, r, imm};
    endfunction

    // Reference model helpers, written from the instruction-set rules.
    function automatic bit m_is_br(input logic [31:0] ins, input logic v);
        logic [5:0] o;
        logic [4:0] r;
        o = ins[31:26];
        r = ins[20:16];
        if (!v) return 1'b0;
        return (o >= 6'd4 && o <= 6'd7) || (o == 6'd1 && r <= 5'd1);
    endfunction

    function automatic bit m_taken(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b);
        int sa;
        sa = a;
        case (ins[31:26])
            6'd4:    return a == b;
            6'd5:    return a != b;
            6'd6:    return sa <= 0;
            6'd7:    return sa > 0;
            default: return (ins[20:16] == 5'd0) ? (sa < 0) : (sa >= 0);
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] ins, input logic [31:0] pc);
        int off;
        off = 4 * int'($signed(ins[15:0]));
        return pc + 32'(4 + off);
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h5;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            5:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [15:0] imm;
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0: return mk(6'd4, 5'($urandom), imm);
            1: return mk(6'd5, 5'($urandom), imm);
            2: return mk(6'd6, 5'd0, imm);
            3: return mk(6'd7, 5'd0, imm);
            4: return mk(6'd1, 5'd0, imm);
            5: return mk(6'd1, 5'd1, imm);
            6: return mk(6'd1, 5'($urandom_range(2, 31)), imm);
            default: return mk(6'd8, 5'($urandom), imm);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bubble();
        instr_d = 32'h0; pc_d = 32'h0; valid_d = 1'b0; opnd_ready = 1'b1;
        rd1 = 32'h0; rd2 = 32'h0; hold = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bubble();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_d = mk(6'd4, 5'd2, 16'h1); valid_d = 1'b1; opnd_ready = 1'b0;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_d); end
        tick();
        do_reset();
        #1;
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_rv: got %b want 0", redirect_valid); end
        n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_rpc: got %h want 0", redirect_pc); end
        n_vec++; if (br_cnt !== 16'h0 || tk_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt: got %h/%h want 0/0", br_cnt, tk_cnt); end
        n_vec++; if (err !== 1'b0 || stall_d !== 1'b0) begin n_err++; $display("FAIL rst_err_stall: got %b/%b want 0/0", err, stall_d); end
    endtask

    task automatic test_beq_taken();
        do_reset();
        instr_d = mk(6'd4, 5'd2, 16'h0004); pc_d = 32'h3000; valid_d = 1'b1;
        opnd_ready = 1'b1; rd1 = 32'd5; rd2 = 32'd5;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL beq_stall: got %b want 0", stall_d); end
        tick();
        bubble();
        n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_rv: got %b want 1", redirect_valid); end
        n_vec++; if (redirect_pc !== 32'h3014) begin n_err++; $display("FAIL beq_rpc: got %h want 3014", redirect_pc); end
        n_vec++; if (br_cnt !== 16'd1 || tk_cnt !== 16'd1) begin n_err++; $display("FAIL beq_cnt: got %0d/%0d want 1/1", br_cnt, tk_cnt); end
        tick();
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_rv_drop: got %b want 0", redirect_valid); end
    endtask

    task automatic test_bltz();
        do_reset();
        instr_d = mk(6'd1, 5'd0, 16'h0002); pc_d = 32'h100; valid_d = 1'b1;
        opnd_ready = 1'b1; rd1 = 32'h0;
        tick();
        bubble();
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bltz_nt_rv: got %b want 0", redirect_valid); end
        n_vec++; if (br_cnt !== 16'd1 || tk_cnt !== 16'd0) begin n_err++; $display("FAIL bltz_nt_cnt: got %0d/%0d want 1/0", br_cnt, tk_cnt); end
        instr_d = mk(6'd1, 5'd0, 16'h0002); pc_d = 32'h100; valid_d = 1'b1; rd1 = 32'h8000_0000;
        tick();
        bubble();
        n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h10C) begin n_err++; $display("FAIL bltz_tk: got %b/%h want 1/0000010c", redirect_valid, redirect_pc); end
        n_vec++; if (br_cnt !== 16'd2 || tk_cnt !== 16'd1) begin n_err++; $display("FAIL bltz_tk_cnt: got %0d/%0d want 2/1", br_cnt, tk_cnt); end
        tick();
    endtask

    task automatic test_wait_resolve();
        do_reset();
        instr_d = mk(6'd5, 5'd2, 16'h0010); pc_d = 32'h2000; valid_d = 1'b1;
        opnd_ready = 1'b0; rd1 = 32'd1; rd2 = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL wait_stall%0d: got %b want 1", i, stall_d); end
            tick();
        end
        opnd_ready = 1'b1;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL wait_stall_res: got %b want 0", stall_d); end
        tick();
        bubble();
        n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2044) begin n_err++; $display("FAIL wait_redir: got %b/%h want 1/00002044", redirect_valid, redirect_pc); end
        n_vec++; if (br_cnt !== 16'd1 || tk_cnt !== 16'd1 || err !== 1'b0) begin n_err++; $display("FAIL wait_cnt_err: got %0d/%0d/%b want 1/1/0", br_cnt, tk_cnt, err); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        instr_d = mk(6'd4, 5'd2, 16'h0001); pc_d = 32'h40; valid_d = 1'b1; opnd_ready = 1'b0;
        for (int i = 0; i < MW; i++) begin
            #1;
            n_vec++; if (stall_d !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL to_wait%0d: got stall %b err %b want 1/0", i, stall_d, err); end
            tick();
        end
        bubble();
        #1;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", err); end
        n_vec++; if (stall_d !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL to_idle: got %b/%b want 0/0", stall_d, redirect_valid); end
        n_vec++; if (br_cnt !== 16'd0 || tk_cnt !== 16'd0) begin n_err++; $display("FAIL to_cnt: got %0d/%0d want 0/0", br_cnt, tk_cnt); end
        tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", err); end
    endtask

    task automatic test_hold_redir();
        do_reset();
        instr_d = mk(6'd7, 5'd0, 16'h0003); pc_d = 32'h500; valid_d = 1'b1;
        opnd_ready = 1'b1; rd1 = 32'd9;
        tick();
        bubble();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) hold = 1'b0;
            #1;
            n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h510) begin n_err++; $display("FAIL hold_rv%0d: got %b/%h want 1/00000510", i, redirect_valid, redirect_pc); end
            n_vec++; if (br_cnt !== 16'd1 || tk_cnt !== 16'd1) begin n_err++; $display("FAIL hold_cnt%0d: got %0d/%0d want 1/1", i, br_cnt, tk_cnt); end
            tick();
        end
        n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL hold_rv_end: got %b want 0", redirect_valid); end
    endtask

    task automatic test_neg_imm_and_reset();
        do_reset();
        instr_d = mk(6'd6, 5'd0, 16'h8000); pc_d = 32'h10; valid_d = 1'b1;
        opnd_ready = 1'b1; rd1 = 32'h0;
        tick();
        bubble();
        n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hFFFE_0014) begin n_err++; $display("FAIL negimm: got %b/%h want 1/fffe0014", redirect_valid, redirect_pc); end
        tick();
        instr_d = mk(6'd4, 5'd2, 16'h0004); pc_d = 32'h80; valid_d = 1'b1; opnd_ready = 1'b0;
        rd1 = 32'd1; rd2 = 32'd1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_vec++; if (stall_d !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin n_err++; $display("FAIL rstwait_out: got %b/%b/%h want 0/0/0", stall_d, redirect_valid, redirect_pc); end
        n_vec++; if (br_cnt !== 16'd0 || tk_cnt !== 16'd0 || err !== 1'b0) begin n_err++; $display("FAIL rstwait_cnt: got %0d/%0d/%b want 0/0/0", br_cnt, tk_cnt, err); end
        tick();
        reset = 1'b1;
        bubble();
        tick();
        n_vec++; if (redirect_valid !== 1'b0 || br_cnt !== 16'd0) begin n_err++; $display("FAIL rstwait_after: got %b/%0d want 0/0", redirect_valid, br_cnt); end
    endtask

    task automatic test_delay_slot_and_nonbranch();
        do_reset();
        instr_d = mk(6'd1, 5'd7, 16'h0004); valid_d = 1'b1; opnd_ready = 1'b0; rd1 = 32'h8000_0000;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL regimm_rt_stall: got %b want 0", stall_d); end
        tick();
        n_vec++; if (br_cnt !== 16'd0 || err !== 1'b0) begin n_err++; $display("FAIL regimm_rt: got %0d/%b want 0/0", br_cnt, err); end
        instr_d = mk(6'd4, 5'd2, 16'h0004); valid_d = 1'b0;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL bubble_stall: got %b want 0", stall_d); end
        valid_d = 1'b1; opnd_ready = 1'b1; rd1 = 32'd3; rd2 = 32'd3; pc_d = 32'h0;
        tick();
        instr_d = mk(6'd5, 5'd2, 16'h0004); rd2 = 32'd4;
        tick();
        bubble();
        n_vec++; if (err !== 1'b1 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL dslot_err: got %b/%b want 1/0", err, redirect_valid); end
        n_vec++; if (br_cnt !== 16'd1 || tk_cnt !== 16'd1) begin n_err++; $display("FAIL dslot_cnt: got %0d/%0d want 1/1", br_cnt, tk_cnt); end
    endtask

    task automatic test_random(input int n);
        bit          pend, redir, e_err, e_stall, br_now;
        int          waited;
        logic [31:0] p_ins, p_pc, e_rpc, u_ins, u_pc;
        logic [15:0] e_br, e_tk;
        do_reset();
        pend = 0; redir = 0; e_err = 0; waited = 0; e_rpc = 0; e_br = 0; e_tk = 0;
        p_ins = 0; p_pc = 0;
        for (int c = 0; c < n; c++) begin
            n_vec++; if (redirect_valid !== redir) begin n_err++; $display("FAIL rand_rv@%0d: got %b want %b", c, redirect_valid, redir); end
            n_vec++; if (redirect_pc !== e_rpc) begin n_err++; $display("FAIL rand_rpc@%0d: got %h want %h", c, redirect_pc, e_rpc); end
            n_vec++; if (br_cnt !== e_br || tk_cnt !== e_tk) begin n_err++; $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d", c, br_cnt, tk_cnt, e_br, e_tk); end
            n_vec++; if (err !== e_err) begin n_err++; $display("FAIL rand_err@%0d: got %b want %b", c, err, e_err); end
            reset      = ($urandom_range(0, 99) != 0);
            hold       = ($urandom_range(0, 99) < 15);
            valid_d    = ($urandom_range(0, 99) < 85);
            opnd_ready = ($urandom_range(0, 99) < 65);
            instr_d    = rand_instr();
            pc_d       = $urandom;
            rd1        = rand_opnd();
            rd2        = $urandom_range(0, 1) ? rd1 : rand_opnd();
            br_now     = m_is_br(instr_d, valid_d);
            if (!reset) begin
                pend = 0; redir = 0; e_err = 0; waited = 0; e_rpc = 0; e_br = 0; e_tk = 0;
            end
            if (!reset || redir) e_stall = 0;
            else if (pend || br_now) e_stall = !opnd_ready;
            else e_stall = 0;
            #1;
            n_vec++; if (stall_d !== e_stall) begin n_err++; $display("FAIL rand_stall@%0d: got %b want %b", c, stall_d, e_stall); end
            if (reset && !hold) begin
                if (redir) begin
                    redir = 0;
                    if (br_now) e_err = 1;
                end else if (pend || br_now) begin
                    u_ins = pend ? p_ins : instr_d;
                    u_pc  = pend ? p_pc : pc_d;
                    if (opnd_ready) begin
                        if (e_br != 16'hFFFF) e_br++;
                        if (m_taken(u_ins, rd1, rd2)) begin
                            if (e_tk != 16'hFFFF) e_tk++;
                            e_rpc = m_target(u_ins, u_pc);
                            redir = 1;
                        end
                        pend = 0; waited = 0;
                    end else begin
                        waited++;
                        if (waited >= MW) begin
                            e_err = 1; pend = 0; waited = 0;
                        end else begin
                            pend = 1; p_ins = u_ins; p_pc = u_pc;
                        end
                    end
                end
            end
            tick();
        end
        reset = 1'b1;
        bubble();
    endtask

    task automatic test_saturation();
        do_reset();
        instr_d = mk(6'd1, 5'd0, 16'h0001); valid_d = 1'b1; opnd_ready = 1'b1; rd1 = 32'h0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        n_vec++; if (br_cnt !== 16'hFFFF || tk_cnt !== 16'h0) begin n_err++; $display("FAIL sat_cnt: got %h/%h want ffff/0000", br_cnt, tk_cnt); end
        bubble();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bubble();
        @(negedge clk);
        test_reset();
        test_beq_taken();
        test_bltz();
        test_wait_resolve();
        test_timeout();
        test_hold_redir();
        test_neg_imm_and_reset();
        test_delay_slot_and_nonbranch();
        test_random(3000);
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 8, giving the maximum number of operand-wait cycles before a timeout error.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port instr_d, input, 32 bits: the decode-stage instruction.
REQ-005 The block SHALL have port pc_d, input, 32 bits: the PC of instr_d.
REQ-006 The block SHALL have port valid_d, input, 1 bit: instr_d is a real instruction, not a bubble.
REQ-007 The block SHALL have port opnd_ready, input, 1 bit: rd1 and rd2 hold final forwarded values.
REQ-008 The block SHALL have ports rd1 and rd2, input, 32 bits each: the rs and rt operands.
REQ-009 The block SHALL have port hold, input, 1 bit: pipeline freeze; the FSM and counters do not advance.
REQ-010 The block SHALL have port stall_d, output, 1 bit: freeze fetch and decode.
REQ-011 The block SHALL have port redirect_valid, output, 1 bit: the PC selects redirect_pc.
REQ-012 The block SHALL have port redirect_pc, output, 32 bits: the branch target.
REQ-013 The block SHALL have port br_cnt, output, 16 bits: the count of resolved branches.
REQ-014 The block SHALL have port tk_cnt, output, 16 bits: the count of taken branches.
REQ-015 The block SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-016 A branch SHALL be decoded when valid_d=1 and one of the following holds:
- op = 000100 (beq) or 000101 (bne);
- op = 000110 (blez) or 000111 (bgtz);
- op = 000001 with rt field 00000 (bltz) or 00001 (bgez).
REQ-017 Any other rt value under op 000001 SHALL NOT be treated as a branch.
REQ-018 The taken condition SHALL be evaluated as follows:
- beq: rd1 == rd2; bne: rd1 != rd2;
- bgtz: signed rd1 > 0; blez: signed rd1 <= 0;
- bltz: signed rd1 < 0; bgez: signed rd1 >= 0.
REQ-019 The target SHALL be pc_d + 4 + (sign-extended instr_d[15:0] << 2), computed modulo 2^32 with wrap-around allowed.
REQ-020 The FSM SHALL have exactly three states: IDLE, WAIT and REDIR.
REQ-021 In IDLE, when a branch is decoded and opnd_ready=1, the block SHALL resolve that same cycle:
- taken: go to REDIR and register redirect_pc;
- not taken: stay in IDLE.
REQ-022 In IDLE, when a branch is decoded and opnd_ready=0, the block SHALL go to WAIT and drive stall_d=1 combinationally that same cycle.
REQ-023 In WAIT, stall_d SHALL be 1, the wait counter SHALL increment each cycle, and the branch SHALL resolve exactly as in REQ-021 in the first cycle with opnd_ready=1.
REQ-024 In WAIT, when the wait counter reaches MAX_WAIT with opnd_ready still 0, the block SHALL set err, return to IDLE and count nothing.
REQ-025 In REDIR, redirect_valid SHALL be 1 with the registered target, and the block SHALL return to IDLE on the next non-hold cycle.
REQ-026 The instruction in decode during REDIR is the delay slot; if it decodes as a branch, the block SHALL set err and SHALL NOT resolve it.
REQ-027 On each resolution, br_cnt SHALL increment, and tk_cnt SHALL also increment when the branch is taken.
REQ-028 br_cnt and tk_cnt SHALL saturate at 0xFFFF.
REQ-029 While hold=1, the state, wait counter, counters and all registered outputs SHALL be frozen, and redirect_valid SHALL stay asserted until a hold=0 cycle has passed in REDIR.
REQ-030 While hold=1, stall_d SHALL keep its combinational value and no resolution SHALL occur.
REQ-031 err SHALL be sticky and clear only on reset.

Reset
REQ-032 When reset=0, the block SHALL asynchronously go to IDLE and clear stall_d, redirect_valid, redirect_pc, br_cnt, tk_cnt, err and the wait counter to 0.
REQ-033 Reset asserted mid-WAIT or in REDIR SHALL abandon the branch, with no count and no redirect after release.
REQ-034 The first resolution SHALL be possible in the first clock edge after reset returns to 1.

Verification
REQ-035 Scenario: beq, rd1=rd2=5, opnd_ready=1, pc_d=0x3000, imm=0x0004 -> next cycle redirect_valid=1 and redirect_pc=0x3014; br_cnt=1 and tk_cnt=1.
REQ-036 Scenario: bltz with rd1=0x00000000 -> not taken, no redirect, br_cnt=1, tk_cnt=0; the same with rd1=0x80000000 -> taken.
REQ-037 Scenario: bne with opnd_ready=0 for 3 cycles -> stall_d=1 for 3 cycles, resolved on the 4th, err=0.
REQ-038 Scenario: opnd_ready held 0 with MAX_WAIT=8 -> err=1 after 8 wait cycles, back in IDLE, counters unchanged.
REQ-039 Scenario: hold=1 for 2 cycles during REDIR -> redirect_valid stays 1 for 3 cycles total with the target unchanged.
REQ-040 Scenario: imm=0x8000 at pc_d=0x00000010 -> redirect_pc=0xFFFE0014; reset pulsed in WAIT -> all outputs 0 and no redirect.
